// File: rtl/mole_if.sv
// Signal bundle between the game controller and the mole scheduler.
// Handshake: there is no valid/ready pair here. Every input is sampled on
// each rising clk edge; tick and btn_hit bits are single-cycle pulses, and
// hit/miss/wrong pulses are single-cycle, registered strobes.
interface mole_if;
    logic       enable;
    logic       tick;
    logic [1:0] difficulty_level;
    logic [7:0] btn_hit;
    logic [7:0] mole_leds;
    logic [2:0] active_idx;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       wrong_pulse;

    modport master (
        output enable, tick, difficulty_level, btn_hit,
        input  mole_leds, active_idx, hit_pulse, miss_pulse, wrong_pulse
    );

    modport slave (
        input  enable, tick, difficulty_level, btn_hit,
        output mole_leds, active_idx, hit_pulse, miss_pulse, wrong_pulse
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole mole sequencer: GAP (all off) -> UP (one mole lit) -> FLASH
// on hit, back to GAP. One 8-bit down-counter times every dwell in ticks.
// All outputs are registered; dbg_state exposes the FSM state.
module mole_scheduler #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [7:0]  UP_T0       = 8'd40,
    parameter logic [7:0]  UP_T1       = 8'd25,
    parameter logic [7:0]  UP_T2       = 8'd15,
    parameter logic [7:0]  UP_T3       = 8'd8,
    parameter logic [7:0]  GAP_TICKS   = 8'd10,
    parameter logic [7:0]  FLASH_TICKS = 8'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    mole_if.slave      bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_UP    = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  leds_q, leds_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        wrong_q, wrong_d;

    logic        dwell_end;
    logic [7:0]  cnt_dec;
    logic [7:0]  up_t_sel;
    logic [2:0]  new_idx;
    logic [7:0]  idx_mask;
    logic        own_hit;
    logic        other_hit;

    // Next-state, counter, LFSR and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        wrong_d = 1'b0;
        leds_d  = 8'h00;

        // LFSR free-runs every cycle regardless of state or enable.
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // A dwell of N ticks ends on the tick that finds the counter at 1.
        dwell_end = bus.tick && (cnt_q == 8'd1);
        cnt_dec   = (bus.tick && (cnt_q > 8'd1)) ? cnt_q - 8'd1 : cnt_q;

        case (bus.difficulty_level)
            2'd0:    up_t_sel = UP_T0;
            2'd1:    up_t_sel = UP_T1;
            2'd2:    up_t_sel = UP_T2;
            default: up_t_sel = UP_T3;
        endcase

        // Bump by one (mod 8) so the same mole never shows twice in a row.
        new_idx = (lfsr_q[2:0] == idx_q) ? lfsr_q[2:0] + 3'd1 : lfsr_q[2:0];

        idx_mask  = 8'd1 << idx_q;
        own_hit   = |(bus.btn_hit & idx_mask);
        other_hit = |(bus.btn_hit & ~idx_mask);

        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_GAP;
                    cnt_d   = GAP_TICKS;
                end
                S_GAP: begin
                    if (dwell_end) begin
                        state_d = S_UP;
                        cnt_d   = up_t_sel;
                        idx_d   = new_idx;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                S_UP: begin
                    if (own_hit) begin
                        hit_d   = 1'b1;
                        state_d = S_FLASH;
                        cnt_d   = FLASH_TICKS;
                    end else if (other_hit) begin
                        // Wrong press keeps the mole up; the timer keeps running.
                        wrong_d = 1'b1;
                        cnt_d   = cnt_dec;
                    end else if (dwell_end) begin
                        miss_d  = 1'b1;
                        state_d = S_GAP;
                        cnt_d   = GAP_TICKS;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                S_FLASH: begin
                    if (dwell_end) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_TICKS;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // LEDs follow the state being entered so they line up with it.
        case (state_d)
            S_UP:    leds_d = 8'd1 << idx_d;
            S_FLASH: leds_d = 8'hFF;
            default: leds_d = 8'h00;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            lfsr_q  <= LFSR_SEED;
            idx_q   <= 3'd0;
            leds_q  <= 8'h00;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            wrong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            leds_q  <= leds_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wrong_q <= wrong_d;
        end
    end

    assign bus.mole_leds   = leds_q;
    assign bus.active_idx  = idx_q;
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;
    assign bus.wrong_pulse = wrong_q;
    assign dbg_state       = state_q;

endmodule
